// File: rtl/image_downsampler.sv
// 2x2 box-average downsampler: reads an IMG_W x IMG_H greyscale image from the image RAM
// and writes the rounded (IMG_W/2) x (IMG_H/2) result, one pixel at a time, to the output RAM.
module image_downsampler #(
   parameter int IMG_W  = 256,
   parameter int IMG_H  = 256,
   parameter int RD_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [15:0] rd_addr,
   input  logic [7:0]  rd_data,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        wr_en,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [15:0] IN_W    = 16'(IMG_W);
   localparam logic [15:0] OUT_W   = 16'(IMG_W / 2);
   localparam logic [15:0] OX_LAST = 16'(IMG_W / 2 - 1);
   localparam logic [15:0] OY_LAST = 16'(IMG_H / 2 - 1);
   localparam logic [15:0] LAT_M1  = 16'(RD_LAT - 1);

   logic [2:0]  r_state;
   logic [15:0] r_ox;
   logic [15:0] r_oy;
   logic [1:0]  r_k;
   logic [9:0]  r_acc;
   logic [15:0] r_cnt;
   logic        r_start_d;

   logic        w_start_edge;
   logic [15:0] w_x;
   logic [15:0] w_y;
   logic [15:0] w_rd_addr;
   logic [15:0] w_wr_addr;
   logic [7:0]  w_round;
   logic        w_last;

   // Tap k selects the input pixel (2ox+k[0], 2oy+k[1]); sums stay within 16 bits for legal sizes.
   assign w_start_edge = start & ~r_start_d;
   assign w_x          = r_ox + r_ox + {15'd0, r_k[0]};
   assign w_y          = r_oy + r_oy + {15'd0, r_k[1]};
   assign w_rd_addr    = w_y * IN_W + w_x;
   assign w_wr_addr    = r_oy * OUT_W + r_ox;
   assign w_round      = 8'((r_acc + 10'd2) >> 2);
   assign w_last       = (r_ox == OX_LAST) && (r_oy == OY_LAST);

   // Sequencer: per output pixel, four LOAD/WAIT tap reads followed by one WRITE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_ox      <= 16'd0;
         r_oy      <= 16'd0;
         r_k       <= 2'd0;
         r_acc     <= 10'd0;
         r_cnt     <= 16'd0;
         r_start_d <= 1'b0;
         rd_addr   <= 16'd0;
         wr_addr   <= 16'd0;
         wr_data   <= 8'd0;
         wr_en     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         r_start_d <= start;
         wr_en     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start_edge) begin
                  done    <= 1'b0;
                  busy    <= 1'b1;
                  r_ox    <= 16'd0;
                  r_oy    <= 16'd0;
                  r_k     <= 2'd0;
                  r_acc   <= 10'd0;
                  r_state <= S_LOAD;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               rd_addr <= w_rd_addr;
               r_cnt   <= LAT_M1;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_cnt == 16'd0) begin
                  r_acc <= r_acc + {2'b00, rd_data};
                  if (r_k != 2'd3) begin
                     r_k     <= r_k + 2'd1;
                     r_state <= S_LOAD;
                  end else begin
                     r_state <= S_WRITE;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            S_WRITE: begin
               wr_en   <= 1'b1;
               wr_addr <= w_wr_addr;
               wr_data <= w_round;
               r_acc   <= 10'd0;
               r_k     <= 2'd0;
               if (r_ox == OX_LAST) begin
                  r_ox <= 16'd0;
                  r_oy <= r_oy + 16'd1;
               end else begin
                  r_ox <= r_ox + 16'd1;
               end
               r_state <= w_last ? S_DONE : S_LOAD;
            end
            S_DONE: begin
               busy    <= 1'b0;
               done    <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_image_downsampler.sv
// Scoreboard bench for image_downsampler: three instances (4x4/lat2, 4x4/lat1, 16x8/lat3),
// expected writes queued at launch and checked by per-instance write monitors.
module tb_image_downsampler;

   typedef struct {
      int addr;
      int data;
      int cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        start_a, start_b, start_c;
   logic [15:0] rd_addr_a, rd_addr_b, rd_addr_c;
   logic [7:0]  rd_data_a, rd_data_b, rd_data_c;
   logic [15:0] wr_addr_a, wr_addr_b, wr_addr_c;
   logic [7:0]  wr_data_a, wr_data_b, wr_data_c;
   logic        wr_en_a, wr_en_b, wr_en_c;
   logic        busy_a, busy_b, busy_c;
   logic        done_a, done_b, done_c;

   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   nwr_a  = 0;
   int   nwr_b  = 0;
   int   nwr_c  = 0;
   int   max_rd_c = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t q_c[$];

   logic [7:0] mem_a [0:15];
   logic [7:0] mem_b [0:15];
   logic [7:0] mem_c [0:127];
   logic [7:0] pipe_a;
   logic [7:0] pipe_c0, pipe_c1;

   image_downsampler #(.IMG_W(4), .IMG_H(4), .RD_LAT(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
      .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_en(wr_en_a), .busy(busy_a), .done(done_a));
   image_downsampler #(.IMG_W(4), .IMG_H(4), .RD_LAT(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
      .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_en(wr_en_b), .busy(busy_b), .done(done_b));
   image_downsampler #(.IMG_W(16), .IMG_H(8), .RD_LAT(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c),
      .wr_addr(wr_addr_c), .wr_data(wr_data_c), .wr_en(wr_en_c), .busy(busy_c), .done(done_c));

   // Image RAM models: data appears RD_LAT edges after the edge that presented the address.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      pipe_a  <= mem_a[rd_addr_a[3:0]];
      pipe_c0 <= mem_c[rd_addr_c[6:0]];
      pipe_c1 <= pipe_c0;
   end
   assign rd_data_a = pipe_a;
   assign rd_data_b = mem_b[rd_addr_b[3:0]];
   assign rd_data_c = pipe_c1;

   function automatic string tag(input int sel);
      case (sel)
         0:       return "a";
         1:       return "b";
         default: return "c";
      endcase
   endfunction

   function automatic logic get_done(input int sel);
      case (sel)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic logic get_busy(input int sel);
      case (sel)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   function automatic int qsize(input int sel);
      case (sel)
         0:       return q_a.size();
         1:       return q_b.size();
         default: return q_c.size();
      endcase
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic set_start(input int sel, input logic v);
      case (sel)
         0:       start_a = v;
         1:       start_b = v;
         default: start_c = v;
      endcase
   endtask

   task automatic push(input int sel, input int a, input int d, input int c);
      exp_t e;
      e.addr = a;
      e.data = d;
      e.cyc  = c;
      case (sel)
         0:       q_a.push_back(e);
         1:       q_b.push_back(e);
         default: q_c.push_back(e);
      endcase
   endtask

   task automatic mon(input int sel, input int a, input int d);
      exp_t e;
      bit   have = 1'b0;
      case (sel)
         0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
         1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
         default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s_unexpected_write: got addr=%0d data=%0d, expected no write", tag(sel), a, d);
      end else begin
         check({tag(sel), "_wr_addr"}, a, e.addr);
         check({tag(sel), "_wr_data"}, d, e.data);
         check({tag(sel), "_wr_cycle"}, cyc, e.cyc);
      end
   endtask

   // Write monitors: pop the scoreboard whenever an instance strobes wr_en.
   always @(negedge clk) begin
      if (wr_en_a) begin nwr_a++; mon(0, int'(wr_addr_a), int'(wr_data_a)); end
      if (wr_en_b) begin nwr_b++; mon(1, int'(wr_addr_b), int'(wr_data_b)); end
      if (wr_en_c) begin nwr_c++; mon(2, int'(wr_addr_c), int'(wr_data_c)); end
      if (int'(rd_addr_c) > max_rd_c) max_rd_c = int'(rd_addr_c);
   end

   // Raise start at a negedge; c0 is the cycle count just after the sampling edge.
   task automatic kick(input int sel, input bit pulse, output int c0);
      @(negedge clk);
      set_start(sel, 1'b1);
      @(posedge clk);
      #1;
      c0 = cyc;
      check({tag(sel), "_busy_after_start"}, int'(get_busy(sel)), 1);
      check({tag(sel), "_done_cleared"}, int'(get_done(sel)), 0);
      if (pulse) begin
         @(negedge clk);
         set_start(sel, 1'b0);
      end
   endtask

   task automatic push4(input int c0, input int gap, input int d0, input int d1, input int d2, input int d3);
      push(0, 0, d0, c0 + gap);
      push(0, 1, d1, c0 + 2 * gap);
      push(0, 2, d2, c0 + 3 * gap);
      push(0, 3, d3, c0 + 4 * gap);
   endtask

   task automatic wait_done(input int sel, input int c0, input int len);
      int t    = 0;
      bit seen = 1'b0;
      while (!seen && t < len + 40) begin
         @(negedge clk);
         t++;
         if (get_done(sel)) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++;
         n_fail++;
         $display("FAIL %s_done_timeout: got done=0 after %0d cycles, expected done=1", tag(sel), t);
      end else begin
         check({tag(sel), "_done_cycle"}, cyc - c0, len);
         check({tag(sel), "_busy_at_done"}, int'(get_busy(sel)), 0);
         check({tag(sel), "_queue_drained"}, qsize(sel), 0);
      end
   endtask

   task automatic load_ramp_a();
      for (int i = 0; i < 16; i++) mem_a[i] = 8'(16 * i);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      int base;
      int t;
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
      load_ramp_a();
      for (int i = 0; i < 16; i++) mem_b[i] = 8'(16 * i);
      for (int y = 0; y < 8; y++)
         for (int x = 0; x < 16; x++) mem_c[y * 16 + x] = 8'(x ^ y);
      repeat (3) @(negedge clk);
      check("a_rst_rd_addr", int'(rd_addr_a), 0);
      check("a_rst_wr_en", int'(wr_en_a), 0);
      check("a_rst_busy", int'(busy_a), 0);
      check("a_rst_done", int'(done_a), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Basic 4x4 ramp run.
      kick(0, 1'b1, c0);
      push4(c0, 13, 40, 72, 168, 200);
      wait_done(0, c0, 53);

      // Rounding corners: 1,1,1,0 / 1,0,0,0 / 2,0,0,0 / all 255.
      for (int i = 0; i < 16; i++) mem_a[i] = 8'd0;
      mem_a[0]  = 8'd1; mem_a[1]  = 8'd1; mem_a[4]  = 8'd1;
      mem_a[2]  = 8'd1; mem_a[8]  = 8'd2;
      mem_a[10] = 8'd255; mem_a[11] = 8'd255; mem_a[14] = 8'd255; mem_a[15] = 8'd255;
      kick(0, 1'b1, c0);
      push4(c0, 13, 1, 0, 1, 255);
      wait_done(0, c0, 53);

      // Start held high through completion: exactly one run.
      load_ramp_a();
      base = nwr_a;
      kick(0, 1'b0, c0);
      push4(c0, 13, 40, 72, 168, 200);
      wait_done(0, c0, 53);
      repeat (40) @(negedge clk);
      check("a_held_start_writes", nwr_a - base, 4);
      check("a_held_start_done", int'(done_a), 1);
      start_a = 1'b0;
      @(negedge clk);

      // Start edge mid-run is ignored.
      base = nwr_a;
      kick(0, 1'b1, c0);
      push4(c0, 13, 40, 72, 168, 200);
      repeat (20) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      wait_done(0, c0, 53);
      repeat (30) @(negedge clk);
      check("a_midrun_start_writes", nwr_a - base, 4);

      // New edge after done: done clears and an identical run follows.
      kick(0, 1'b1, c0);
      push4(c0, 13, 40, 72, 168, 200);
      wait_done(0, c0, 53);

      // Reset between two writes.
      base = nwr_a;
      kick(0, 1'b1, c0);
      push4(c0, 13, 40, 72, 168, 200);
      t = 0;
      while (nwr_a == base && t < 60) begin @(negedge clk); t++; end
      check("a_first_write_before_reset", nwr_a - base, 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("a_midrst_rd_addr", int'(rd_addr_a), 0);
      check("a_midrst_wr_addr", int'(wr_addr_a), 0);
      check("a_midrst_wr_data", int'(wr_data_a), 0);
      check("a_midrst_wr_en", int'(wr_en_a), 0);
      check("a_midrst_busy", int'(busy_a), 0);
      check("a_midrst_done", int'(done_a), 0);
      q_a.delete();
      repeat (20) @(negedge clk);
      check("a_no_write_in_reset", nwr_a - base, 1);
      check("a_done_low_in_reset", int'(done_a), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      kick(0, 1'b1, c0);
      push4(c0, 13, 40, 72, 168, 200);
      wait_done(0, c0, 53);

      // RD_LAT=1: same data, writes 9 cycles apart.
      kick(1, 1'b1, c0);
      push(1, 0, 40, c0 + 9);
      push(1, 1, 72, c0 + 18);
      push(1, 2, 168, c0 + 27);
      push(1, 3, 200, c0 + 36);
      wait_done(1, c0, 37);

      // 16x8 sweep with pixel = x^y at RD_LAT=3 (17 cycles per pixel).
      kick(2, 1'b1, c0);
      for (int oy = 0; oy < 4; oy++) begin
         for (int ox = 0; ox < 8; ox++) begin
            int s;
            s = ((2 * ox) ^ (2 * oy)) + ((2 * ox + 1) ^ (2 * oy)) +
                ((2 * ox) ^ (2 * oy + 1)) + ((2 * ox + 1) ^ (2 * oy + 1));
            push(2, oy * 8 + ox, (s + 2) / 4, c0 + 17 * (oy * 8 + ox + 1));
         end
      end
      wait_done(2, c0, 545);
      check("c_write_count", nwr_c, 32);
      check("c_last_rd_addr", int'(rd_addr_c), 127);
      check("c_max_rd_addr", max_rd_c, 127);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/image_downsampler.md
# image_downsampler

Downsampling engine that runs after a received image has been written into the image RAM. On start, it reads the IMG_W x IMG_H 8-bit greyscale image through the RAM's external address/data port and computes a rounded 2x2 box average for each output pixel. It then writes the (IMG_W/2) x (IMG_H/2) result through a simple write port to the output RAM, which the UART transmit path later retrieves.

## Interface
- IMG_W, 256, input image width in pixels; even, ≥2
- IMG_H, 256, input image height in pixels; even, ≥2; IMG_W*IMG_H ≤ 65536
- RD_LAT, 2, image RAM read latency in cycles from address edge to data sample edge; ≥1
- clk  in  1  system clock (the PLL output clock); all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  a rising edge (0→1, sampled on clk) launches a run; ignored while busy=1
- rd_addr  out  16  image RAM read address, registered
- rd_data  in  8  image RAM read data
- wr_addr  out  16  output RAM write address, registered
- wr_data  out  8  output RAM write data, registered
- wr_en  out  1  output RAM write strobe, one cycle per output pixel
- busy  out  1  high from the cycle after the start edge until DONE is entered
- done  out  1  sticky completion flag; cleared by the next accepted start edge

## Operation
- Reset values: rd_addr=0, wr_addr=0, wr_data=0, wr_en=0, busy=0, done=0; state=IDLE; ox=oy=k=0; acc=0; start edge detector history=0.
- Coordinates:
  - Output pixel: (ox, oy), with ox in 0..IMG_W/2-1 and oy in 0..IMG_H/2-1.
  - Tap k=0..3 reads input (2ox+k[0], 2oy+k[1]).
  - rd_addr = y*IMG_W + x, computed in 16 bits with no overflow given the parameter rules.
- IDLE:
  - On a start edge: clear done, ox=oy=k=0, acc=0, set busy.
  - Next state: LOAD.
- LOAD (1 cycle):
  - Register rd_addr for tap k.
  - Load the wait counter with RD_LAT-1.
  - Next state: WAIT.
- WAIT:
  - Count down.
  - On the cycle the counter is 0, the edge does acc += rd_data. acc is 10 bits unsigned.
  - If k<3: k++, go to LOAD. Otherwise go to WRITE.
- WRITE (1 cycle):
  - Drive wr_en=1, wr_addr = oy*(IMG_W/2)+ox, wr_data = (acc+2)>>2. This is round-half-up; the maximum value 1022>>2=255 always fits.
  - Clear acc and k.
  - Advance ox. On wrap (ox = IMG_W/2-1), set ox=0 and oy++.
  - If the pixel just written was the last one, go to DONE. Otherwise go to LOAD.
- DONE (1 cycle):
  - busy=0, done=1.
  - Next state: IDLE. done stays high.
- Output ordering: raster order, row-major; wr_addr increments by exactly 1 per write, starting at 0.
- start held high: no retrigger. A new run needs start to go low, then high again.
- Start edge while busy: ignored. The edge is not queued.
- rst_n asserted mid-run: immediate return to reset values. No partial write is completed, and done stays 0.
- rd_addr keeps its last value when idle. The image RAM mux owner is responsible for selecting this port only when the image RAM is in its idle/processing phase.

## Timing
- Start edge sampled at edge E0 → busy=1 and state=LOAD after E0. The first rd_addr is valid after E0+1.
- Per read tap: 1 (LOAD) + RD_LAT (WAIT) cycles. rd_data is sampled RD_LAT edges after the edge that loaded rd_addr.
- Per output pixel: 4*(RD_LAT+1)+1 cycles. With RD_LAT=2, that is 13.
- Total run from E0 to done=1: (IMG_W/2)*(IMG_H/2)*(4*(RD_LAT+1)+1) + 1 cycles. Defaults give 212,993.
- wr_en is high for exactly one cycle per pixel, and wr_addr/wr_data are valid in that same cycle.
- Writes are spaced 4*(RD_LAT+1)+1 cycles apart.
- No back-pressure: the output RAM must accept a write every cycle that wr_en is high.

## Test plan
- Basic 4x4 run (IMG_W=IMG_H=4, RD_LAT=2, RAM model with latency 2):
  - Stimulus: pixel[i]=16*i, start pulse.
  - Required: writes (0,40), (1,72), (2,168), (3,200) in order, each exactly 13 cycles apart; done=1 and busy=0 after 53 cycles.
- Rounding:
  - Taps 1,1,1,0 → wr_data=1.
  - Taps 1,0,0,0 → wr_data=0.
  - Taps 2,0,0,0 → wr_data=1.
  - All taps 255 → wr_data=255 (no wrap).
- Address sweep at defaults (256x256):
  - Stimulus: pixel = x^y.
  - Required: 16,384 writes; wr_addr runs 0..16383 with no gaps; the last read address is 65535; rd_addr never exceeds 65535.
- Start handling:
  - Start held high through completion → exactly one run.
  - Start edge mid-run → ignored; the write count is unchanged.
  - Low→high after done → done clears and a second identical run executes.
- Reset mid-run:
  - Stimulus: assert rst_n=0 between two writes.
  - Required: all outputs at reset values immediately; no further wr_en; a following start produces a clean full run from wr_addr=0.
- RD_LAT=1 variant:
  - Required: the 4x4 case gives identical data, with writes 9 cycles apart.
